critical_error_collector: RTL and testbench

//  Collects core-level critical-error sources and confirms them.

---
 rtl/critical_error_collector_if.sv | 26 ++
 rtl/critical_error_collector.sv | 112 +++++++++++
 tb/tb_critical_error_collector.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/critical_error_collector_if.sv
// critical_error_collector_if: error-source inputs and difftest/halt outputs of the collector.
interface critical_error_collector_if #(parameter int NUM_SRC = 8, parameter int TS_WIDTH = 32);
   localparam int SRC_W = $clog2(NUM_SRC + 1);
   logic [7:0]          io_hartId;
   logic [NUM_SRC-1:0]  io_err_vld;
   logic [NUM_SRC-1:0]  io_err_mask;
   logic                io_commit;
   logic                io_diff_enable;
   logic                io_diff_valid;
   logic                io_diff_criticalError;
   logic [7:0]          io_diff_coreid;
   logic                io_halt_req;
   logic [SRC_W-1:0]    io_first_src;
   logic [NUM_SRC-1:0]  io_cause;
   logic [TS_WIDTH-1:0] io_timestamp;
   modport master (
      output io_hartId, io_err_vld, io_err_mask, io_commit,
      input  io_diff_enable, io_diff_valid, io_diff_criticalError, io_diff_coreid,
             io_halt_req, io_first_src, io_cause, io_timestamp
   );
   modport slave (
      input  io_hartId, io_err_vld, io_err_mask, io_commit,
      output io_diff_enable, io_diff_valid, io_diff_criticalError, io_diff_coreid,
             io_halt_req, io_first_src, io_cause, io_timestamp
   );
endinterface

// File: rtl/critical_error_collector.sv
// critical_error_collector: confirms masked error sources, emits one difftest report per reset, sticky halt.
// Optional commit watchdog enabled by defining CRITICAL_ERROR_WATCHDOG_EN.
module critical_error_collector #(
   parameter int NUM_SRC        = 8,
   parameter int CONFIRM_CYCLES = 2,
   parameter int TS_WIDTH       = 32,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input logic clock,
   input logic reset,
   critical_error_collector_if.slave io
);
   localparam int SRC_W = $clog2(NUM_SRC + 1);
   localparam int CW    = $clog2(CONFIRM_CYCLES + 1);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] PEND   = 2'd1;
   localparam logic [1:0] REPORT = 2'd2;
   localparam logic [1:0] HALT   = 2'd3;

   logic [1:0]          state_q, state_d;
   logic [CW-1:0]       conf_q, conf_d;
   logic [TS_WIDTH-1:0] cyc_q, cyc_d, ts_q, ts_d;
   logic [NUM_SRC-1:0]  cause_q, cause_d, masked;
   logic [SRC_W-1:0]    src_q, src_d, first;
   logic [7:0]          id_q, id_d;
   logic                err_any, cap, wd_hit;

   assign masked  = io.io_err_vld & io.io_err_mask;
   assign err_any = |masked;

   always_comb begin
      first = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (masked[i]) first = SRC_W'(i);
   end

`ifdef CRITICAL_ERROR_WATCHDOG_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WW-1:0] wd_q, wd_d;
   logic          wd_active;
   assign wd_active = (state_q == IDLE) || (state_q == PEND);
   always_comb begin
      wd_d   = wd_active ? (io.io_commit ? '0 : wd_q + WW'(1)) : wd_q;
      wd_hit = wd_active && !io.io_commit && (wd_d == WW'(TIMEOUT_CYCLES));
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) wd_q <= '0;
      else       wd_q <= wd_d;
`else
   logic unused_commit;
   assign unused_commit = io.io_commit;
   assign wd_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      conf_d  = conf_q;
      cap     = 1'b0;
      cyc_d   = &cyc_q ? cyc_q : cyc_q + TS_WIDTH'(1);
      case (state_q)
         IDLE: if (err_any) begin
            conf_d  = CW'(1);
            cap     = (CONFIRM_CYCLES == 1);
            state_d = cap ? REPORT : PEND;
         end
         PEND: if (!err_any) begin
            conf_d  = '0;
            state_d = IDLE;
         end else begin
            conf_d  = conf_q + CW'(1);
            cap     = (conf_d == CW'(CONFIRM_CYCLES));
            state_d = cap ? REPORT : PEND;
         end
         REPORT: state_d = HALT;
         default: ;
      endcase
      // A real confirmation in the same cycle outranks the watchdog capture.
      if (wd_hit && !cap) state_d = REPORT;
      cause_d = cap ? masked : wd_hit ? '0 : cause_q;
      src_d   = cap ? first : wd_hit ? SRC_W'(NUM_SRC) : src_q;
      ts_d    = (cap || wd_hit) ? cyc_q : ts_q;
      id_d    = (cap || wd_hit) ? io.io_hartId : id_q;
   end

   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         conf_q  <= '0;
         cyc_q   <= '0;
         ts_q    <= '0;
         cause_q <= '0;
         src_q   <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         conf_q  <= conf_d;
         cyc_q   <= cyc_d;
         ts_q    <= ts_d;
         cause_q <= cause_d;
         src_q   <= src_d;
         id_q    <= id_d;
      end

   assign io.io_diff_enable        = (state_q == REPORT);
   assign io.io_diff_valid         = (state_q == REPORT);
   assign io.io_diff_criticalError = (state_q == REPORT);
   assign io.io_halt_req           = (state_q == REPORT) || (state_q == HALT);
   assign io.io_diff_coreid        = id_q;
   assign io.io_first_src          = src_q;
   assign io.io_cause              = cause_q;
   assign io.io_timestamp          = ts_q;
endmodule

// File: tb/tb_critical_error_collector.sv
// tb_critical_error_collector: table-driven vectors plus hand sequences for the error collector.
module tb_critical_error_collector;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   critical_error_collector_if #(.NUM_SRC(8), .TS_WIDTH(32)) bus ();
   critical_error_collector #(.NUM_SRC(8), .CONFIRM_CYCLES(2), .TS_WIDTH(32), .TIMEOUT_CYCLES(16))
      dut (.clock(clock), .reset(reset), .io(bus.slave));

   typedef struct {
      logic [7:0] hart;
      logic [7:0] vld;
      logic [7:0] mask;
      int         hold;
      logic       rep;
      logic [3:0] src;
      logic [7:0] cause;
   } vec_t;

   vec_t vecs[7];
   int checks = 0, failures = 0;
   int cyc, pulses, pcyc, stray;
   logic [7:0] p_id, p_cause;
   logic [3:0] p_src;
   logic [31:0] p_ts;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
      if ((bus.io_diff_valid !== bus.io_diff_enable) || (bus.io_diff_criticalError !== bus.io_diff_enable)) stray++;
      if (bus.io_diff_enable) begin
         pulses++;
         pcyc    = cyc;
         p_id    = bus.io_diff_coreid;
         p_src   = bus.io_first_src;
         p_cause = bus.io_cause;
         p_ts    = bus.io_timestamp;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.io_hartId   = '0;
      bus.io_err_vld  = '0;
      bus.io_err_mask = '0;
      bus.io_commit   = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset  = 1'b0;
      cyc    = 0;
      pulses = 0;
      pcyc   = -1;
      stray  = 0;
   endtask

   task automatic run(input vec_t v, input int idx);
      do_reset();
      bus.io_hartId   = v.hart;
      bus.io_err_mask = v.mask;
      for (int n = 1; n <= 30; n++) begin
         step();
         bus.io_err_vld = (cyc >= 10 && cyc < 10 + v.hold) ? v.vld : 8'h00;
      end
      chk($sformatf("v%0d_pulses", idx), pulses, {63'd0, v.rep});
      chk($sformatf("v%0d_halt", idx), bus.io_halt_req, v.rep);
      chk($sformatf("v%0d_cause", idx), bus.io_cause, v.rep ? v.cause : 8'h00);
      chk($sformatf("v%0d_stray", idx), stray, 0);
      if (v.rep) begin
         chk($sformatf("v%0d_cycle", idx), pcyc, 12);
         chk($sformatf("v%0d_coreid", idx), p_id, v.hart);
         chk($sformatf("v%0d_src", idx), p_src, v.src);
         chk($sformatf("v%0d_pcause", idx), p_cause, v.cause);
         chk($sformatf("v%0d_ts", idx), p_ts, 11);
      end
   endtask

   initial begin
      vecs[0] = '{8'h03, 8'h04, 8'hFF, 5,  1'b1, 4'd2, 8'h04};
      vecs[1] = '{8'h01, 8'h01, 8'hFF, 1,  1'b0, 4'd0, 8'h00};
      vecs[2] = '{8'h07, 8'h90, 8'h7F, 3,  1'b1, 4'd4, 8'h10};
      vecs[3] = '{8'hA5, 8'h81, 8'hFF, 2,  1'b1, 4'd0, 8'h81};
      vecs[4] = '{8'h02, 8'h80, 8'h7F, 10, 1'b0, 4'd0, 8'h00};
      vecs[5] = '{8'h02, 8'h00, 8'hFF, 10, 1'b0, 4'd0, 8'h00};
      vecs[6] = '{8'h3C, 8'h60, 8'hFF, 40, 1'b1, 4'd5, 8'h60};

      // Reset state and 100 quiet cycles.
      do_reset();
      reset = 1'b1;
      #1;
      chk("rst_enable", bus.io_diff_enable, 0);
      chk("rst_halt", bus.io_halt_req, 0);
      chk("rst_src", bus.io_first_src, 0);
      chk("rst_cause", bus.io_cause, 0);
      chk("rst_ts", bus.io_timestamp, 0);
      chk("rst_coreid", bus.io_diff_coreid, 0);
      do_reset();
      bus.io_err_mask = 8'hFF;
      for (int n = 1; n <= 100; n++) step();
      chk("idle_pulses", pulses, 0);
      chk("idle_halt", bus.io_halt_req, 0);
      chk("idle_ts", bus.io_timestamp, 0);

      for (int i = 0; i < 7; i++) run(vecs[i], i);

      // Source switches mid-confirmation, then later errors must not re-trigger.
      do_reset();
      bus.io_hartId   = 8'h05;
      bus.io_err_mask = 8'hFF;
      for (int n = 1; n <= 40; n++) begin
         step();
         bus.io_err_vld = (cyc == 10) ? 8'h01 : (cyc == 11) ? 8'h02 : (cyc >= 14) ? 8'hFF : 8'h00;
      end
      chk("sw_pulses", pulses, 1);
      chk("sw_cycle", pcyc, 12);
      chk("sw_src", p_src, 1);
      chk("sw_cause", bus.io_cause, 8'h02);
      chk("sw_ts", bus.io_timestamp, 11);
      chk("sw_halt", bus.io_halt_req, 1);

      // Masking all sources in PEND drops back to IDLE, restarting confirmation.
      do_reset();
      bus.io_err_mask = 8'hFF;
      for (int n = 1; n <= 30; n++) begin
         step();
         bus.io_err_vld  = (cyc >= 10) ? 8'h01 : 8'h00;
         bus.io_err_mask = (cyc == 11) ? 8'h00 : 8'hFF;
      end
      chk("mask_pulses", pulses, 1);
      chk("mask_cycle", pcyc, 14);
      chk("mask_ts", p_ts, 13);

      // Reset asserted in the REPORT cycle clears everything at once.
      do_reset();
      bus.io_hartId   = 8'h03;
      bus.io_err_mask = 8'hFF;
      for (int n = 1; n <= 12; n++) begin
         step();
         bus.io_err_vld = (cyc >= 10) ? 8'h04 : 8'h00;
      end
      chk("rr_pulse_seen", pcyc, 12);
      reset = 1'b1;
      #1;
      chk("rr_enable", bus.io_diff_enable, 0);
      chk("rr_valid", bus.io_diff_valid, 0);
      chk("rr_halt", bus.io_halt_req, 0);
      chk("rr_cause", bus.io_cause, 0);
      chk("rr_coreid", bus.io_diff_coreid, 0);
      run(vecs[0], 7);

`ifdef CRITICAL_ERROR_WATCHDOG_EN
      do_reset();
      bus.io_commit   = 1'b0;
      bus.io_err_mask = 8'hFF;
      for (int n = 1; n <= 30; n++) step();
      chk("wd_pulses", pulses, 1);
      chk("wd_cycle", pcyc, 16);
      chk("wd_src", p_src, 8);
      chk("wd_cause", p_cause, 0);
      chk("wd_ts", p_ts, 15);
      do_reset();
      bus.io_commit   = 1'b0;
      bus.io_err_mask = 8'hFF;
      for (int n = 1; n <= 60; n++) begin
         step();
         bus.io_commit = (cyc % 10 == 0);
      end
      chk("wd_commit_pulses", pulses, 0);
      chk("wd_commit_halt", bus.io_halt_req, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
